// File: rtl/basic_control_unit.sv
// Timing and control unit for the 16-bit basic computer.
// Ports: clk/rst_n, start, ir + AC/DR/E flags in; bus select, register/memory strobes, ALU op, sc, halted out.
module basic_control_unit #(
    parameter int W  = 16,
    parameter int AW = 12
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [W-1:0] i_ir,
    input  logic         i_ac_zero,
    input  logic         i_ac_neg,
    input  logic         i_dr_zero,
    input  logic         i_e_flg,
    output logic [2:0]   o_bus_sel,
    output logic         o_ar_ld,
    output logic         o_ar_inc,
    output logic         o_pc_ld,
    output logic         o_pc_inc,
    output logic         o_dr_ld,
    output logic         o_dr_inc,
    output logic         o_ir_ld,
    output logic         o_ac_ld,
    output logic         o_ac_clr,
    output logic         o_ac_inc,
    output logic         o_e_ld,
    output logic         o_e_clr,
    output logic         o_e_cmp,
    output logic         o_mem_rd,
    output logic         o_mem_wr,
    output logic [2:0]   o_alu_op,
    output logic         o_alu_e,
    output logic [2:0]   o_sc,
    output logic         o_halted
);
    localparam logic [2:0] BUS_AR  = 3'd1;
    localparam logic [2:0] BUS_PC  = 3'd2;
    localparam logic [2:0] BUS_DR  = 3'd3;
    localparam logic [2:0] BUS_AC  = 3'd4;
    localparam logic [2:0] BUS_IR  = 3'd5;
    localparam logic [2:0] BUS_MEM = 3'd7;

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t      r_state, w_state_nx;
    logic [2:0]  r_sc, w_sc_nx;
    logic        r_i, w_i_nx;
    logic [2:0]  r_d, w_d_nx;
    logic [AW-1:0] w_rr;
    logic        w_regref;
    logic        w_hlt;
    logic        w_clr;

    assign w_rr     = i_ir[AW-1:0];
    assign w_regref = (r_d == 3'd7) && !r_i;
    // HLT only fires when bit 0 is the highest set bit
    assign w_hlt    = (r_state == S_RUN) && (r_sc == 3'd3) && w_regref
                      && (w_rr == 12'h001);

    always_comb begin
        w_clr = 1'b0;
        unique case (r_sc)
            3'd3:    w_clr = (r_d == 3'd7);
            3'd4:    w_clr = (r_d == 3'd3) || (r_d == 3'd4);
            3'd5:    w_clr = (r_d <= 3'd2) || (r_d == 3'd5);
            3'd6:    w_clr = 1'b1;
            default: w_clr = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_sc    <= 3'd0;
            r_i     <= 1'b0;
            r_d     <= 3'd0;
        end else begin
            r_state <= w_state_nx;
            r_sc    <= w_sc_nx;
            r_i     <= w_i_nx;
            r_d     <= w_d_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_sc_nx    = r_sc;
        w_i_nx     = r_i;
        w_d_nx     = r_d;
        unique case (r_state)
            S_IDLE: begin
                w_sc_nx = 3'd0;
                if (i_start) w_state_nx = S_RUN;
            end
            S_RUN: begin
                if (w_hlt) begin
                    w_state_nx = S_IDLE;
                    w_sc_nx    = 3'd0;
                end else if (w_clr) begin
                    w_sc_nx = 3'd0;
                end else begin
                    w_sc_nx = r_sc + 3'd1;
                end
                if (r_sc == 3'd2) begin
                    w_i_nx = i_ir[W-1];
                    w_d_nx = i_ir[W-2:W-4];
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        o_bus_sel = 3'd0;
        o_ar_ld   = 1'b0;
        o_ar_inc  = 1'b0;
        o_pc_ld   = 1'b0;
        o_pc_inc  = 1'b0;
        o_dr_ld   = 1'b0;
        o_dr_inc  = 1'b0;
        o_ir_ld   = 1'b0;
        o_ac_ld   = 1'b0;
        o_ac_clr  = 1'b0;
        o_ac_inc  = 1'b0;
        o_e_ld    = 1'b0;
        o_e_clr   = 1'b0;
        o_e_cmp   = 1'b0;
        o_mem_rd  = 1'b0;
        o_mem_wr  = 1'b0;
        o_alu_op  = 3'd0;
        o_alu_e   = 1'b0;
        o_sc      = r_sc;
        o_halted  = (r_state == S_IDLE);
        if (r_state == S_RUN) begin
            unique case (r_sc)
                3'd0: begin
                    o_bus_sel = BUS_PC;
                    o_ar_ld   = 1'b1;
                end
                3'd1: begin
                    o_bus_sel = BUS_MEM;
                    o_mem_rd  = 1'b1;
                    o_ir_ld   = 1'b1;
                    o_pc_inc  = 1'b1;
                end
                3'd2: begin
                    o_bus_sel = BUS_IR;
                    o_ar_ld   = 1'b1;
                end
                3'd3: begin
                    if (w_regref) begin
                        // only the highest set bit executes
                        priority case (1'b1)
                            w_rr[11]: o_ac_clr = 1'b1;
                            w_rr[10]: o_e_clr  = 1'b1;
                            w_rr[9]: begin
                                o_ac_ld  = 1'b1;
                                o_alu_op = 3'd3;
                            end
                            w_rr[8]:  o_e_cmp  = 1'b1;
                            w_rr[7]: begin
                                o_ac_ld  = 1'b1;
                                o_e_ld   = 1'b1;
                                o_alu_op = 3'd4;
                                o_alu_e  = 1'b1;
                            end
                            w_rr[6]: begin
                                o_ac_ld  = 1'b1;
                                o_e_ld   = 1'b1;
                                o_alu_op = 3'd5;
                                o_alu_e  = 1'b1;
                            end
                            w_rr[5]:  o_ac_inc = 1'b1;
                            w_rr[4]:  o_pc_inc = !i_ac_neg;
                            w_rr[3]:  o_pc_inc = i_ac_neg;
                            w_rr[2]:  o_pc_inc = i_ac_zero;
                            w_rr[1]:  o_pc_inc = !i_e_flg;
                            default:  o_pc_inc = 1'b0;
                        endcase
                    end else if (r_i && r_d != 3'd7) begin
                        o_bus_sel = BUS_MEM;
                        o_mem_rd  = 1'b1;
                        o_ar_ld   = 1'b1;
                    end
                end
                3'd4: begin
                    unique case (r_d)
                        3'd0, 3'd1, 3'd2, 3'd6: begin
                            o_bus_sel = BUS_MEM;
                            o_mem_rd  = 1'b1;
                            o_dr_ld   = 1'b1;
                        end
                        3'd3: begin
                            o_bus_sel = BUS_AC;
                            o_mem_wr  = 1'b1;
                        end
                        3'd4: begin
                            o_bus_sel = BUS_AR;
                            o_pc_ld   = 1'b1;
                        end
                        3'd5: begin
                            o_bus_sel = BUS_PC;
                            o_mem_wr  = 1'b1;
                            o_ar_inc  = 1'b1;
                        end
                        default: o_bus_sel = 3'd0;
                    endcase
                end
                3'd5: begin
                    unique case (r_d)
                        3'd0: begin
                            o_ac_ld  = 1'b1;
                            o_alu_op = 3'd1;
                        end
                        3'd1: begin
                            o_ac_ld  = 1'b1;
                            o_e_ld   = 1'b1;
                            o_alu_op = 3'd0;
                        end
                        3'd2: begin
                            o_ac_ld  = 1'b1;
                            o_alu_op = 3'd2;
                        end
                        3'd5: begin
                            o_bus_sel = BUS_AR;
                            o_pc_ld   = 1'b1;
                        end
                        3'd6: o_dr_inc = 1'b1;
                        default: o_dr_inc = 1'b0;
                    endcase
                end
                3'd6: begin
                    if (r_d == 3'd6) begin
                        o_bus_sel = BUS_DR;
                        o_mem_wr  = 1'b1;
                        o_pc_inc  = i_dr_zero;
                    end
                end
                default: o_bus_sel = 3'd0;
            endcase
        end
    end
endmodule

// File: tb/tb_basic_control_unit.sv
// Directed self-checking bench for basic_control_unit.
// Checks the full output vector at each timing step of several instructions.
module tb_basic_control_unit;
    localparam logic [14:0] AR_LD  = 15'h4000;
    localparam logic [14:0] AR_INC = 15'h2000;
    localparam logic [14:0] PC_LD  = 15'h1000;
    localparam logic [14:0] PC_INC = 15'h0800;
    localparam logic [14:0] DR_LD  = 15'h0400;
    localparam logic [14:0] DR_INC = 15'h0200;
    localparam logic [14:0] IR_LD  = 15'h0100;
    localparam logic [14:0] AC_LD  = 15'h0080;
    localparam logic [14:0] AC_CLR = 15'h0040;
    localparam logic [14:0] AC_INC = 15'h0020;
    localparam logic [14:0] E_LD   = 15'h0010;
    localparam logic [14:0] E_CLR  = 15'h0008;
    localparam logic [14:0] E_CMP  = 15'h0004;
    localparam logic [14:0] MEM_RD = 15'h0002;
    localparam logic [14:0] MEM_WR = 15'h0001;

    logic        clk, rst_n, start;
    logic [15:0] ir;
    logic        ac_zero, ac_neg, dr_zero, e_flg;
    logic [2:0]  bus_sel, alu_op, sc;
    logic        ar_ld, ar_inc, pc_ld, pc_inc, dr_ld, dr_inc, ir_ld;
    logic        ac_ld, ac_clr, ac_inc, e_ld, e_clr, e_cmp;
    logic        mem_rd, mem_wr, alu_e, halted;
    int          n_chk = 0;
    int          n_err = 0;

    basic_control_unit #(.W(16), .AW(12)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_ir(ir),
        .i_ac_zero(ac_zero), .i_ac_neg(ac_neg),
        .i_dr_zero(dr_zero), .i_e_flg(e_flg),
        .o_bus_sel(bus_sel), .o_ar_ld(ar_ld), .o_ar_inc(ar_inc),
        .o_pc_ld(pc_ld), .o_pc_inc(pc_inc), .o_dr_ld(dr_ld),
        .o_dr_inc(dr_inc), .o_ir_ld(ir_ld), .o_ac_ld(ac_ld),
        .o_ac_clr(ac_clr), .o_ac_inc(ac_inc), .o_e_ld(e_ld),
        .o_e_clr(e_clr), .o_e_cmp(e_cmp), .o_mem_rd(mem_rd),
        .o_mem_wr(mem_wr), .o_alu_op(alu_op), .o_alu_e(alu_e),
        .o_sc(sc), .o_halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [2:0] e_bus,
                       input logic [14:0] e_strb, input logic [2:0] e_op,
                       input logic e_ae, input logic [2:0] e_sc,
                       input logic e_halt);
        logic [25:0] obs, exp;
        obs = {bus_sel, ar_ld, ar_inc, pc_ld, pc_inc, dr_ld, dr_inc,
               ir_ld, ac_ld, ac_clr, ac_inc, e_ld, e_clr, e_cmp,
               mem_rd, mem_wr, alu_op, alu_e, sc, halted};
        exp = {e_bus, e_strb, e_op, e_ae, e_sc, e_halt};
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%07h expected=%07h", tag, obs, exp);
        end
    endtask

    task automatic fetch(input string nm, input logic [15:0] v);
        chk({nm, "_T0"}, 3'd2, AR_LD, 3'd0, 1'b0, 3'd0, 1'b0);
        ir = v;
        step();
        chk({nm, "_T1"}, 3'd7, MEM_RD | IR_LD | PC_INC, 3'd0, 1'b0,
            3'd1, 1'b0);
        step();
        chk({nm, "_T2"}, 3'd5, AR_LD, 3'd0, 1'b0, 3'd2, 1'b0);
        step();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; ir = 16'h0;
        ac_zero = 1'b0; ac_neg = 1'b0; dr_zero = 1'b0; e_flg = 1'b0;
        #3;
        chk("reset", 3'd0, 15'h0, 3'd0, 1'b0, 3'd0, 1'b1);
        step();
        rst_n = 1'b1;
        step();
        chk("idle", 3'd0, 15'h0, 3'd0, 1'b0, 3'd0, 1'b1);
        start = 1'b1;
        step();
        start = 1'b0;

        fetch("add", 16'h1123);
        chk("add_T3", 3'd0, 15'h0, 3'd0, 1'b0, 3'd3, 1'b0);
        step();
        chk("add_T4", 3'd7, MEM_RD | DR_LD, 3'd0, 1'b0, 3'd4, 1'b0);
        step();
        chk("add_T5", 3'd0, AC_LD | E_LD, 3'd0, 1'b0, 3'd5, 1'b0);
        step();

        fetch("ldai", 16'hA123);
        chk("ldai_T3", 3'd7, MEM_RD | AR_LD, 3'd0, 1'b0, 3'd3, 1'b0);
        step();
        chk("ldai_T4", 3'd7, MEM_RD | DR_LD, 3'd0, 1'b0, 3'd4, 1'b0);
        step();
        chk("ldai_T5", 3'd0, AC_LD, 3'd2, 1'b0, 3'd5, 1'b0);
        step();

        fetch("isz", 16'h6050);
        step();
        chk("isz_T4", 3'd7, MEM_RD | DR_LD, 3'd0, 1'b0, 3'd4, 1'b0);
        step();
        chk("isz_T5", 3'd0, DR_INC, 3'd0, 1'b0, 3'd5, 1'b0);
        dr_zero = 1'b1;
        step();
        chk("isz_T6_z", 3'd3, MEM_WR | PC_INC, 3'd0, 1'b0, 3'd6, 1'b0);
        dr_zero = 1'b0;
        #1;
        chk("isz_T6_nz", 3'd3, MEM_WR, 3'd0, 1'b0, 3'd6, 1'b0);
        step();

        fetch("sta", 16'h3010);
        step();
        chk("sta_T4", 3'd4, MEM_WR, 3'd0, 1'b0, 3'd4, 1'b0);
        step();

        fetch("bun", 16'h4020);
        step();
        chk("bun_T4", 3'd1, PC_LD, 3'd0, 1'b0, 3'd4, 1'b0);
        step();

        fetch("bsa", 16'h5030);
        step();
        chk("bsa_T4", 3'd2, MEM_WR | AR_INC, 3'd0, 1'b0, 3'd4, 1'b0);
        step();
        chk("bsa_T5", 3'd1, PC_LD, 3'd0, 1'b0, 3'd5, 1'b0);
        step();

        fetch("cir", 16'h7080);
        chk("cir_T3", 3'd0, AC_LD | E_LD, 3'd4, 1'b1, 3'd3, 1'b0);
        step();

        fetch("cla", 16'h7A00);
        chk("cla_T3", 3'd0, AC_CLR, 3'd0, 1'b0, 3'd3, 1'b0);
        step();

        fetch("spa", 16'h7011);
        chk("spa_T3", 3'd0, PC_INC, 3'd0, 1'b0, 3'd3, 1'b0);
        ac_neg = 1'b1;
        #1;
        chk("spa_T3_neg", 3'd0, 15'h0, 3'd0, 1'b0, 3'd3, 1'b0);
        ac_neg = 1'b0;
        step();

        fetch("hlt", 16'h7001);
        chk("hlt_T3", 3'd0, 15'h0, 3'd0, 1'b0, 3'd3, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("halted", 3'd0, 15'h0, 3'd0, 1'b0, 3'd0, 1'b1);
        step();
        chk("halted2", 3'd0, 15'h0, 3'd0, 1'b0, 3'd0, 1'b1);
        start = 1'b1;
        step();
        start = 1'b0;

        fetch("add2", 16'h1123);
        step();
        step();
        chk("add2_T5", 3'd0, AC_LD | E_LD, 3'd0, 1'b0, 3'd5, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", 3'd0, 15'h0, 3'd0, 1'b0, 3'd0, 1'b1);
        step();
        chk("rst_hold", 3'd0, 15'h0, 3'd0, 1'b0, 3'd0, 1'b1);
        rst_n = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        fetch("refetch", 16'h7000);
        chk("nop_T3", 3'd0, 15'h0, 3'd0, 1'b0, 3'd3, 1'b0);
        step();
        chk("nop_next", 3'd2, AR_LD, 3'd0, 1'b0, 3'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
